fetch_unit: RTL

Instruction fetch stage directly upstream of `decoder`. Owns the program counter, issues one instruction-memory request at a time, and presents each fetched word and its PC to the decoder with a valid/ready handshake. Redirects from execute (branch, JAL, JALR) replace the PC. A request already in flight when a redirect arrives is discarded on return.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// the reset-time NOP word and the sequential PC step. Honours FETCH_MISALIGN_CHECK_EN.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_S_FETCH = 2'd0,
    FETCH_S_KILL  = 2'd1,
    FETCH_S_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
    , FETCH_S_FAULT = 2'd3
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Sequential fetch address; wraps silently at the top of the address space.
  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding and
// hands words to the decoder. Optional feature macro: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  output logic [1:0]  state_dbg
);

  // Handshakes: imem transfers when imem_req && imem_ack (req held until ack,
  // address stable meanwhile); the decoder takes inst when inst_valid && inst_ready,
  // unless a redirect lands in the same cycle, which squashes the held word.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  redir_target;
  logic         take;
  logic [31:0]  land_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic pending_bad_q, pending_bad_d;
  logic redir_bad;
  logic land_bad;

  assign redir_target = redirect_pc;
  assign redir_bad    = |redirect_pc[1:0];
`else
  assign redir_target = redirect_pc & ~32'h3;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_S_FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q       <= 1'b0;
      pending_bad_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q       <= fault_d;
      pending_bad_q <= pending_bad_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    take         = 1'b0;
    land_pc      = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d       = fault_q;
    pending_bad_d = pending_bad_q;
    land_bad      = 1'b0;
`endif

    // "take" means a redirect target (or the pending one) lands this cycle.
    case (state_q)
      FETCH_S_FETCH: begin
        if (redirect_valid && imem_ack) begin
          take    = 1'b1;
          land_pc = redir_target;
`ifdef FETCH_MISALIGN_CHECK_EN
          land_bad = redir_bad;
`endif
        end else if (redirect_valid) begin
          pending_pc_d = redir_target;
`ifdef FETCH_MISALIGN_CHECK_EN
          pending_bad_d = redir_bad;
`endif
          state_d = FETCH_S_KILL;
        end else if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_next_seq(pc_q);
          state_d      = FETCH_S_HOLD;
        end
      end

      FETCH_S_KILL: begin
        if (redirect_valid) begin
          pending_pc_d = redir_target;
`ifdef FETCH_MISALIGN_CHECK_EN
          pending_bad_d = redir_bad;
`endif
        end
        if (imem_ack) begin
          take    = 1'b1;
          land_pc = redirect_valid ? redir_target : pending_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
          land_bad = redirect_valid ? redir_bad : pending_bad_q;
`endif
        end
      end

      FETCH_S_HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          take         = 1'b1;
          land_pc      = redir_target;
`ifdef FETCH_MISALIGN_CHECK_EN
          land_bad = redir_bad;
`endif
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = FETCH_S_FETCH;
        end
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      FETCH_S_FAULT: begin
        if (redirect_valid) begin
          take     = 1'b1;
          land_pc  = redir_target;
          land_bad = redir_bad;
        end
      end
`endif

      default: state_d = FETCH_S_FETCH;
    endcase

    if (take) begin
      pc_d    = land_pc;
      state_d = FETCH_S_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d = 1'b0;
      // A misaligned target parks the stage; the faulting address is reported on inst_pc.
      if (land_bad) begin
        pc_d         = pc_q;
        state_d      = FETCH_S_FAULT;
        fault_d      = 1'b1;
        inst_pc_d    = land_pc;
        inst_valid_d = 1'b0;
      end
`endif
    end
  end

  // Reset drops the request combinationally so memory abandons it in the same cycle.
  assign imem_req   = ~reset & ((state_q == FETCH_S_FETCH) | (state_q == FETCH_S_KILL));
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q & ~reset;
  assign state_dbg  = state_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`endif

endmodule
